// File: rtl/mmu_controller_nxn.sv
// NxN matrix-multiply tile: element-wise operand load, output-stationary systolic MAC grid, registered C read port.
// Optional MMU_SIGNED_EN build treats operands as two's-complement; default is unsigned.

module mmu_pe #(
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a_in,
  input  logic [DW-1:0]    b_in,
  output logic [DW-1:0]    a_out,
  output logic [DW-1:0]    b_out,
  output logic [ACC_W-1:0] acc_nxt
);
  logic [DW-1:0]    a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d, prod;

`ifdef MMU_SIGNED_EN
  logic signed [2*DW-1:0] p_s;
  assign p_s  = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{b_in[DW-1]}}, b_in});
  assign prod = ACC_W'(p_s);
`else
  logic [2*DW-1:0] p_u;
  assign p_u  = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
  assign prod = ACC_W'(p_u);
`endif

  always_comb begin
    a_d   = a_in;
    b_d   = b_in;
    acc_d = acc_q;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign acc_nxt = acc_d;
endmodule

module mmu_controller_nxn #(
  parameter int N     = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic                   load_sel_ab,
  input  logic [$clog2(N)-1:0]   load_row,
  input  logic [$clog2(N)-1:0]   load_col,
  input  logic [DW-1:0]          in_data,
  input  logic                   output_en,
  input  logic [$clog2(N)-1:0]   output_row,
  input  logic [$clog2(N)-1:0]   output_col,
  output logic [ACC_W-1:0]       out_data,
  output logic                   out_valid,
  output logic                   done,
  output logic                   busy
);
  localparam int IDX_W = $clog2(N);
  localparam int BM_W  = $clog2(N*N);
  localparam int CNT_W = $clog2(3*N);
  localparam int RD_W  = $clog2(N*N+1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RD_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [N*N-1:0]       a_ld_q, a_ld_d, b_ld_q, b_ld_d;
  logic [DW-1:0]        a_mem_q [N][N];
  logic [DW-1:0]        a_mem_d [N][N];
  logic [DW-1:0]        b_mem_q [N][N];
  logic [DW-1:0]        b_mem_d [N][N];
  logic [ACC_W-1:0]     c_q [N][N];
  logic [ACC_W-1:0]     c_d [N][N];
  logic [ACC_W-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d, done_q, done_d, busy_q, busy_d;

  logic                 ld_ok, rd_ok, pe_clr, pe_en;
  logic [BM_W-1:0]      ld_idx;
  logic [N-1:0][DW-1:0] a_feed, b_feed;
  logic [N-1:0][N-1:0][DW-1:0]    pe_a_in, pe_b_in, pe_a_out, pe_b_out;
  logic [N-1:0][N-1:0][ACC_W-1:0] pe_acc;

  assign ld_ok  = load_en && (state_q == S_IDLE) &&
                  (int'(load_row) < N) && (int'(load_col) < N);
  assign rd_ok  = output_en && (state_q == S_OUT) &&
                  (int'(output_row) < N) && (int'(output_col) < N);
  assign ld_idx = BM_W'(int'(load_row) * N + int'(load_col));
  assign pe_clr = (state_q == S_IDLE) && (state_d == S_FEED);
  assign pe_en  = (state_q == S_FEED) || (state_q == S_DRAIN);

  // Skewed feed: row i / column j see element t-i / t-j of their operand; zeros outside the window.
  always_comb begin
    a_feed = '0;
    b_feed = '0;
    for (int i = 0; i < N; i++) begin
      if ((state_q == S_FEED) && (int'(cnt_q) >= i) && (int'(cnt_q) - i < N)) begin
        a_feed[i] = a_mem_q[i][IDX_W'(int'(cnt_q) - i)];
        b_feed[i] = b_mem_q[IDX_W'(int'(cnt_q) - i)][i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_cnt_d    = rd_cnt_q;
    a_ld_d      = a_ld_q;
    b_ld_d      = b_ld_q;
    a_mem_d     = a_mem_q;
    b_mem_d     = b_mem_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_ok) begin
          if (load_sel_ab) begin
            b_mem_d[load_row][load_col] = in_data;
            b_ld_d[ld_idx]              = 1'b1;
          end else begin
            a_mem_d[load_row][load_col] = in_data;
            a_ld_d[ld_idx]              = 1'b1;
          end
        end
        if ((&a_ld_d) && (&b_ld_d)) begin
          state_d = S_FEED;
          cnt_d   = '0;
        end
      end
      S_FEED: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(2*N-2)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        // Snapshot the post-edge accumulator values so the final product lands in C.
        if (cnt_q == CNT_W'(3*N-3)) begin
          state_d = S_OUT;
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              c_d[i][j] = pe_acc[i][j];
        end
      end
      S_OUT: begin
        if (rd_ok) begin
          out_data_d  = c_q[output_row][output_col];
          out_valid_d = 1'b1;
          rd_cnt_d    = rd_cnt_q + 1'b1;
          if (rd_cnt_q == RD_W'(N*N-1)) begin
            state_d  = S_IDLE;
            rd_cnt_d = '0;
            a_ld_d   = '0;
            b_ld_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_q == S_DRAIN) && (state_d == S_OUT);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      a_ld_q      <= '0;
      b_ld_q      <= '0;
      c_q         <= '{default: '0};
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      a_ld_q      <= a_ld_d;
      b_ld_q      <= b_ld_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    a_mem_q <= a_mem_d;
    b_mem_q <= b_mem_d;
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_al
        assign pe_a_in[i][j] = a_feed[i];
      end else begin : g_ai
        assign pe_a_in[i][j] = pe_a_out[i][j-1];
      end
      if (i == 0) begin : g_bt
        assign pe_b_in[i][j] = b_feed[j];
      end else begin : g_bi
        assign pe_b_in[i][j] = pe_b_out[i-1][j];
      end
      mmu_pe #(.DW(DW), .ACC_W(ACC_W)) u_pe (
        .clk     (clk),
        .rst     (rst),
        .clr     (pe_clr),
        .en      (pe_en),
        .a_in    (pe_a_in[i][j]),
        .b_in    (pe_b_in[i][j]),
        .a_out   (pe_a_out[i][j]),
        .b_out   (pe_b_out[i][j]),
        .acc_nxt (pe_acc[i][j])
      );
    end
  end

  logic unused_edge;
  always_comb begin
    unused_edge = 1'b0;
    for (int k = 0; k < N; k++)
      unused_edge = unused_edge ^ (^pe_a_out[k][N-1]) ^ (^pe_b_out[N-1][k]);
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = busy_q;
endmodule
